// File: rtl/req_memory_pkg.sv
// req_memory shared types: sweep/run state enum and the
// even-parity helper used by the optional parity storage.
package req_memory_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/req_memory_array.sv
// req_memory_array: single-port byte-write storage, registered read.
// Ports: clk, reset (async low), en/we/addr/wdata/be/inj in, rdata/rerr out.
// Macro REQ_MEMORY_PARITY_EN adds one even-parity bit per byte.
module req_memory_array
  import req_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic                    inj,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rerr
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset; the init sweep rewrites them.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Read register only moves on a read so the response holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

`ifdef REQ_MEMORY_PARITY_EN
  logic [NB-1:0] par [DEPTH];
  logic [NB-1:0] bad;

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          par[addr][i] <= byte_parity(wdata[i*8 +: 8]) ^ inj;
        end
      end
    end
  end

  always_comb begin
    bad = '0;
    for (int i = 0; i < NB; i++) begin
      bad[i] = byte_parity(mem[addr][i*8 +: 8]) ^ par[addr][i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rerr <= 1'b0;
    end else if (en && !we) begin
      rerr <= |bad;
    end
  end
`else
  logic unused_inj;
  assign unused_inj = inj;
  assign rerr       = 1'b0;
`endif

endmodule

// File: rtl/req_memory.sv
// req_memory: init-swept request/response memory with 1 or 2 cycle reads.
// Ports: clk, reset (async low), init_req, req_* handshake, rsp_*, busy.
// Macro REQ_MEMORY_PARITY_EN enables per-byte parity and err_inj.
module req_memory
  import req_memory_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 4,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init_req,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  input  logic                    err_inj,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    busy
);

  localparam int NB = DATA_WIDTH / 8;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  acc;

  logic                  a_en;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic [NB-1:0]         a_be;
  logic                  a_inj;
  logic [DATA_WIDTH-1:0] a_rdata;
  logic                  a_rerr;
  logic                  rd_v1;

  // Counter runs only while sweeping and sits at 0 in RUN,
  // so re-entering INIT always starts from address 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == INIT) ? cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT: if (cnt == {ADDR_WIDTH{1'b1}}) state_nxt = RUN;
      RUN:  if (init_req) state_nxt = INIT;
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    busy      = (state == INIT);
    req_ready = (state == RUN) && !init_req;
  end

  assign acc = req_valid && req_ready;

  // The sweep owns the array port; requests cannot be accepted then.
  always_comb begin
    if (state == INIT) begin
      a_en    = 1'b1;
      a_we    = 1'b1;
      a_addr  = cnt;
      a_wdata = INIT_VALUE;
      a_be    = '1;
      a_inj   = 1'b0;
    end else begin
      a_en    = acc;
      a_we    = req_write;
      a_addr  = req_addr;
      a_wdata = req_wdata;
      a_be    = req_be;
      a_inj   = err_inj;
    end
  end

  req_memory_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .en    (a_en),
    .we    (a_we),
    .addr  (a_addr),
    .wdata (a_wdata),
    .be    (a_be),
    .inj   (a_inj),
    .rdata (a_rdata),
    .rerr  (a_rerr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_v1 <= 1'b0;
    else        rd_v1 <= acc && !req_write;
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  rd_v2;
    logic [DATA_WIDTH-1:0] rd_d2;
    logic                  rd_e2;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd_v2 <= 1'b0;
        rd_d2 <= '0;
        rd_e2 <= 1'b0;
      end else begin
        rd_v2 <= rd_v1;
        if (rd_v1) begin
          rd_d2 <= a_rdata;
          rd_e2 <= a_rerr;
        end
      end
    end

    assign rsp_valid = rd_v2;
    assign rsp_rdata = rd_d2;
    assign rsp_err   = rd_e2;
  end else begin : g_lat1
    assign rsp_valid = rd_v1;
    assign rsp_rdata = a_rdata;
    assign rsp_err   = a_rerr;
  end

endmodule

// File: tb/tb_req_memory.sv
// tb_req_memory: drives latency-1 and latency-2 instances in lockstep
// from a directed vector table plus init/reset corner sequences.
module tb_req_memory;

  localparam logic [31:0] F = 32'hFFFF_FFFF;
  localparam logic [31:0] P = 32'hFF22_FF44;
  localparam logic [31:0] D = 32'hDEAD_BEEF;
  localparam logic [31:0] Q = 32'hFFFF_FFAB;
`ifdef REQ_MEMORY_PARITY_EN
  localparam logic PE = 1'b1;
`else
  localparam logic PE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        init_req;
  logic        req_valid;
  logic        req_write;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        err_inj;

  logic        rdy1, v1, e1, busy1;
  logic [31:0] d1;
  logic        rdy2, v2, e2, busy2;
  logic [31:0] d2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  req_memory #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .init_req(init_req),
    .req_valid(req_valid), .req_ready(rdy1),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .err_inj(err_inj), .rsp_valid(v1),
    .rsp_rdata(d1), .rsp_err(e1), .busy(busy1)
  );

  req_memory #(.READ_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .init_req(init_req),
    .req_valid(req_valid), .req_ready(rdy2),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .err_inj(err_inj), .rsp_valid(v2),
    .rsp_rdata(d2), .rsp_err(e2), .busy(busy2)
  );

  typedef struct {
    logic        v;
    logic        w;
    logic [3:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
    logic        inj;
    logic        ev1;
    logic [31:0] ed1;
    logic        ee1;
    logic        ev2;
    logic [31:0] ed2;
    logic        ee2;
  } vec_t;

  vec_t tbl [18];
  vec_t t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic v, input logic w,
                       input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic inj);
    init_req  = ir;
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    err_inj   = inj;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0);
  endtask

  task automatic chk_sweep(input string tag, input logic quiet);
    for (int i = 0; i < 16; i++) begin
      #1;
      chk($sformatf("%s busy c%0d", tag, i), {31'd0, busy1}, 1);
      chk($sformatf("%s rdy c%0d", tag, i), {31'd0, rdy2}, 0);
      if (quiet) begin
        chk($sformatf("%s v1 c%0d", tag, i), {31'd0, v1}, 0);
        chk($sformatf("%s v2 c%0d", tag, i), {31'd0, v2}, 0);
      end
      @(posedge clk);
      #1;
    end
    #1;
    chk({tag, " busy end"}, {31'd0, busy2}, 0);
    chk({tag, " rdy end"}, {31'd0, rdy1}, 1);
  endtask

  initial begin
    tbl[0]  = '{1'b1,1'b0,4'd5,32'h0,4'h0,1'b0, 1'b1,F,1'b0, 1'b0,32'h0,1'b0};
    tbl[1]  = '{1'b1,1'b1,4'd3,32'h11223344,4'h5,1'b0,
                1'b0,F,1'b0, 1'b1,F,1'b0};
    tbl[2]  = '{1'b1,1'b0,4'd3,32'h0,4'h0,1'b0, 1'b1,P,1'b0, 1'b0,F,1'b0};
    tbl[3]  = '{1'b1,1'b1,4'd7,D,4'hF,1'b0, 1'b0,P,1'b0, 1'b1,P,1'b0};
    tbl[4]  = '{1'b1,1'b0,4'd7,32'h0,4'h0,1'b0, 1'b1,D,1'b0, 1'b0,P,1'b0};
    tbl[5]  = '{1'b1,1'b0,4'd3,32'h0,4'h0,1'b0, 1'b1,P,1'b0, 1'b1,D,1'b0};
    tbl[6]  = '{1'b1,1'b0,4'd7,32'h0,4'h0,1'b0, 1'b1,D,1'b0, 1'b1,P,1'b0};
    tbl[7]  = '{1'b1,1'b0,4'd5,32'h0,4'h0,1'b0, 1'b1,F,1'b0, 1'b1,D,1'b0};
    tbl[8]  = '{1'b1,1'b0,4'd3,32'h0,4'h0,1'b0, 1'b1,P,1'b0, 1'b1,F,1'b0};
    tbl[9]  = '{1'b0,1'b0,4'd0,32'h0,4'h0,1'b0, 1'b0,P,1'b0, 1'b1,P,1'b0};
    tbl[10] = '{1'b0,1'b0,4'd0,32'h0,4'h0,1'b0, 1'b0,P,1'b0, 1'b0,P,1'b0};
    tbl[11] = '{1'b1,1'b1,4'd7,32'h0,4'h0,1'b0, 1'b0,P,1'b0, 1'b0,P,1'b0};
    tbl[12] = '{1'b1,1'b0,4'd7,32'h0,4'h0,1'b0, 1'b1,D,1'b0, 1'b0,P,1'b0};
    tbl[13] = '{1'b1,1'b1,4'd2,32'hAB,4'h1,1'b1, 1'b0,D,1'b0, 1'b1,D,1'b0};
    tbl[14] = '{1'b1,1'b0,4'd2,32'h0,4'h0,1'b0, 1'b1,Q,PE, 1'b0,D,1'b0};
    tbl[15] = '{1'b1,1'b1,4'd2,32'hAB,4'h1,1'b0, 1'b0,Q,1'b0, 1'b1,Q,PE};
    tbl[16] = '{1'b1,1'b0,4'd2,32'h0,4'h0,1'b0, 1'b1,Q,1'b0, 1'b0,Q,1'b0};
    tbl[17] = '{1'b0,1'b0,4'd0,32'h0,4'h0,1'b0, 1'b0,Q,1'b0, 1'b1,Q,1'b0};

    // Reset state, then the 16-cycle power-up sweep.
    reset = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst rdy1", {31'd0, rdy1}, 0);
    chk("rst busy1", {31'd0, busy1}, 1);
    chk("rst v1", {31'd0, v1}, 0);
    chk("rst v2", {31'd0, v2}, 0);
    chk("rst d1", d1, 0);
    chk("rst d2", d2, 0);
    chk("rst e1", {31'd0, e1}, 0);
    chk("rst e2", {31'd0, e2}, 0);
    reset = 1'b1;
    chk_sweep("por", 1'b1);

    // Vector table: reads, partial writes, RAW, back-to-back, parity.
    for (int i = 0; i < 18; i++) begin
      t = tbl[i];
      drive(1'b0, t.v, t.w, t.a, t.d, t.be, t.inj);
      #1;
      chk($sformatf("r%0d rdy", i), {31'd0, rdy1}, 1);
      @(posedge clk);
      #1;
      chk($sformatf("r%0d v1", i), {31'd0, v1}, {31'd0, t.ev1});
      chk($sformatf("r%0d d1", i), d1, t.ed1);
      chk($sformatf("r%0d v2", i), {31'd0, v2}, {31'd0, t.ev2});
      chk($sformatf("r%0d d2", i), d2, t.ed2);
      if (t.ev1) chk($sformatf("r%0d e1", i), {31'd0, e1}, {31'd0, t.ee1});
      if (t.ev2) chk($sformatf("r%0d e2", i), {31'd0, e2}, {31'd0, t.ee2});
    end

    // Read in flight across init_req; init_req during sweep ignored.
    drive(1'b0, 1'b1, 1'b0, 4'd7, 32'd0, 4'd0, 1'b0);
    @(posedge clk);
    #1;
    chk("ir v1", {31'd0, v1}, 1);
    chk("ir d1", d1, D);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0);
    #1;
    chk("ir rdy1 low", {31'd0, rdy1}, 0);
    chk("ir rdy2 low", {31'd0, rdy2}, 0);
    @(posedge clk);
    #1;
    chk("ir v2", {31'd0, v2}, 1);
    chk("ir d2", d2, D);
    chk("ir v1 gone", {31'd0, v1}, 0);
    for (int i = 0; i < 16; i++) begin
      drive(i == 5, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0);
      #1;
      chk($sformatf("ir busy c%0d", i), {31'd0, busy2}, 1);
      chk($sformatf("ir rdy c%0d", i), {31'd0, rdy1}, 0);
      @(posedge clk);
      #1;
    end
    idle();
    #1;
    chk("ir busy end", {31'd0, busy1}, 0);
    chk("ir rdy end", {31'd0, rdy2}, 1);
    for (int a = 0; a < 16; a++) begin
      drive(1'b0, 1'b1, 1'b0, a[3:0], 32'd0, 4'd0, 1'b0);
      @(posedge clk);
      #1;
      chk($sformatf("swp v1 a%0d", a), {31'd0, v1}, 1);
      chk($sformatf("swp d1 a%0d", a), d1, F);
      if (a > 0) begin
        chk($sformatf("swp v2 a%0d", a), {31'd0, v2}, 1);
        chk($sformatf("swp d2 a%0d", a), d2, F);
      end
    end
    idle();
    @(posedge clk);
    #1;
    chk("swp v2 last", {31'd0, v2}, 1);
    chk("swp d2 last", d2, F);
    chk("swp v1 idle", {31'd0, v1}, 0);

    // Reset with a read in flight: response dropped, sweep restarts.
    drive(1'b0, 1'b1, 1'b0, 4'd3, 32'd0, 4'd0, 1'b0);
    @(posedge clk);
    #1;
    chk("rr v1 pre", {31'd0, v1}, 1);
    reset = 1'b0;
    idle();
    #1;
    chk("rr v1", {31'd0, v1}, 0);
    chk("rr d1", d1, 0);
    chk("rr d2", d2, 0);
    chk("rr busy", {31'd0, busy1}, 1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rr hold v2 c%0d", i), {31'd0, v2}, 0);
    end
    reset = 1'b1;
    chk_sweep("rr", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
